// File: rtl/mult_div_unit.sv
// mult_div_unit: EX-stage multiply/divide unit that holds the HI/LO registers.
// A launched operation latches its op and operands, then runs for a fixed
// number of cycles (MULT_CYCLES or DIV_CYCLES). HI/LO are written only on the
// final edge of the run, or by mthi/mtlo while the unit is idle.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dataRs,
  input  logic [31:0] dataRt,
  input  logic        wrHi,
  input  logic        wrLo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  // The counter is loaded with N-1 so that it reaches zero on the Nth busy cycle.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  md_op_e           op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;

  logic             launch;
  logic             finish;
  logic             idle_write;

  logic [31:0]      result_hi;
  logic [31:0]      result_lo;

  // Signed/unsigned arithmetic working values.
  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_by_zero;
  logic               div_overflow;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s_safe;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] b_u_safe;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;

  assign launch     = (state == IDLE) && start;
  assign finish     = (state == RUN) && (cnt == '0);
  // A start in the same cycle takes priority over mthi/mtlo, so the writes drop.
  assign idle_write = (state == IDLE) && !start;
  assign busy       = (state == RUN);

  // State and cycle counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter logic: load on launch, count down while running.
  // NOTE: every variable is given a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          cnt_next   = op[1] ? DIV_LOAD : MULT_LOAD;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Capture op and operands at launch; later input changes cannot disturb the run.
  // NOTE: these are plain registers, not a memory array, so they take a reset
  // value; that keeps them deterministic after reset at negligible cost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
    end else if (launch) begin
      op_q <= md_op_e'(op);
      a_q  <= dataRs;
      b_q  <= dataRt;
    end
  end

  // Result datapath from the latched operands; only consumed on the final edge.
  always_comb begin
    a_sx   = {{32{a_q[31]}}, a_q};
    b_sx   = {{32{b_q[31]}}, b_q};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a_q} * {32'd0, b_q};

    div_by_zero  = (b_q == 32'd0);
    div_overflow = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

    // Divisors are steered to 1 in the special cases so the dividers never
    // see a zero divisor or the single overflowing signed pair.
    a_s      = $signed(a_q);
    b_s_safe = (div_by_zero || div_overflow) ? 32'sd1 : $signed(b_q);
    quot_s   = a_s / b_s_safe;
    rem_s    = a_s % b_s_safe;

    b_u_safe = div_by_zero ? 32'd1 : b_q;
    quot_u   = a_q / b_u_safe;
    rem_u    = a_q % b_u_safe;

    result_hi = '0;
    result_lo = '0;
    case (op_q)
      OP_MULT: begin
        result_hi = prod_s[63:32];
        result_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        result_hi = prod_u[63:32];
        result_lo = prod_u[31:0];
      end
      OP_DIV: begin
        if (div_by_zero) begin
          result_hi = a_q;
          result_lo = 32'hFFFF_FFFF;
        end else if (div_overflow) begin
          result_hi = 32'd0;
          result_lo = 32'h8000_0000;
        end else begin
          result_hi = rem_s;
          result_lo = quot_s;
        end
      end
      OP_DIVU: begin
        if (div_by_zero) begin
          result_hi = a_q;
          result_lo = 32'hFFFF_FFFF;
        end else begin
          result_hi = rem_u;
          result_lo = quot_u;
        end
      end
      default: begin
        result_hi = '0;
        result_lo = '0;
      end
    endcase
  end

  // HI/LO registers: result on the final run edge, mthi/mtlo only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
      hi <= result_hi;
      lo <= result_lo;
    end else if (idle_write) begin
      if (wrHi) hi <= wdata;
      if (wrLo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against
// a reference model built from 64-bit integer arithmetic.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dataRs;
  logic [31:0] dataRt;
  logic        wrHi;
  logic        wrLo;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the architectural HI/LO registers.
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_unit #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .dataRs(dataRs),
    .dataRt(dataRt),
    .wrHi  (wrHi),
    .wrLo  (wrLo),
    .wdata (wdata),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference result {hi, lo} computed with wide integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'd0: res = sa * sb;
      2'd1: res = ua * ub;
      2'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;   // truncates toward zero; 64-bit so no overflow
          r   = sa % sb;   // sign follows dividend
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return res;
  endfunction

  // Launch one operation, watch it run, and check latency and final HI/LO.
  // disturb: mid-run start pulse plus mthi; wr_with_start: mtlo in the start cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit wr_with_start);
    logic [63:0] res;
    int          n;
    int          cnt;
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    dataRs = a;
    dataRt = b;
    if (wr_with_start) begin
      wrLo  = 1'b1;
      wdata = 32'h5555_AAAA;
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    wrLo   = 1'b0;
    op     = 2'($urandom);
    dataRs = $urandom;
    dataRt = $urandom;
    n   = o[1] ? DIV_N : MULT_N;
    res = ref_result(o, a, b);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      check("hold_hilo", {hi, lo}, {exp_hi, exp_lo});
      if (disturb && cnt == 2) begin
        start  = 1'b1;
        op     = ~o;
        dataRs = $urandom;
        dataRt = $urandom;
        wrHi   = 1'b1;
        wdata  = 32'h0000_1234;
      end else begin
        start = 1'b0;
        wrHi  = 1'b0;
      end
    end
    start = 1'b0;
    wrHi  = 1'b0;
    check("busy_cycles", 64'(cnt), 64'(n));
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    check("result_hilo", {hi, lo}, {exp_hi, exp_lo});
  endtask

  // mthi/mtlo in idle: one-edge latency, busy stays low.
  task automatic write_hilo(input logic wh, input logic wl, input logic [31:0] d);
    @(negedge clk);
    wrHi  = wh;
    wrLo  = wl;
    wdata = d;
    @(posedge clk);
    #1;
    wrHi = 1'b0;
    wrLo = 1'b0;
    if (wh) exp_hi = d;
    if (wl) exp_lo = d;
    check("mt_hilo", {hi, lo}, {exp_hi, exp_lo});
    check("mt_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    reset  = 1'b1;
    start  = 1'b0;
    op     = '0;
    dataRs = '0;
    dataRt = '0;
    wrHi   = 1'b0;
    wrLo   = 1'b0;
    wdata  = '0;

    // Reset state.
    #12;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // MULT/MULTU on -3 * 7, with literal expectations as well.
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    check("mult_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    check("multu_lit", {hi, lo}, 64'h0000_0006_FFFF_FFEB);

    // DIV/DIVU and divide boundaries.
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd3, 32'd7, 32'd2, 1'b0, 1'b0);
    check("divu_lit", {hi, lo}, 64'h0000_0001_0000_0003);
    run_op(2'd2, 32'd5, 32'd0, 1'b0, 1'b0);
    check("div0_lit", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    run_op(2'd3, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    check("divu0_lit", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("divovf_lit", {hi, lo}, 64'h0000_0000_8000_0000);

    // Mid-run start pulse and mthi are ignored.
    run_op(2'd0, 32'h0001_0003, 32'hFFFF_0005, 1'b1, 1'b0);
    run_op(2'd3, 32'hDEAD_BEEF, 32'd13, 1'b1, 1'b0);

    // Idle mthi/mtlo, then start beats a simultaneous mtlo.
    write_hilo(1'b1, 1'b1, 32'hCAFE_0001);
    check("mt_lit", {hi, lo}, 64'hCAFE_0001_CAFE_0001);
    write_hilo(1'b1, 1'b0, 32'h0BAD_F00D);
    write_hilo(1'b0, 1'b1, 32'h1357_9BDF);
    run_op(2'd1, 32'd100, 32'd200, 1'b0, 1'b1);

    // Randomized operations with occasional special operands and idle writes.
    for (int k = 0; k < 40; k++) begin
      r_op = 2'($urandom);
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(1, 9));
        2: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        3: r_a = -32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(r_op, r_a, r_b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0)
        write_hilo(1'($urandom), 1'($urandom), $urandom);
    end

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start  = 1'b1;
    op     = 2'd2;
    dataRs = 32'd1000;
    dataRt = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    repeat (DIV_N + 4) @(negedge clk);
    check("post_rst_hilo", {hi, lo}, {exp_hi, exp_lo});
    check("post_rst_busy", 64'(busy), 64'd0);

    // Unit is usable again after the aborted run.
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
